// File: rtl/rice_block_decoder_if.sv
// Handshake bundle between the bit unpacker (master) and the Rice block decoder (slave).
interface rice_block_decoder_if #(
    parameter int unsigned J_W    = 6,
    parameter int unsigned K_W    = 5,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              stop;
    logic [J_W-1:0]    j;
    logic [K_W-1:0]    k;
    logic              mode;
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic [DATA_W-1:0] samp_out;
    logic              samp_valid;
    logic [J_W-1:0]    samp_idx;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, stop, j, k, mode, bit_in, bit_valid,
        input  bit_ready, samp_out, samp_valid, samp_idx, busy, done, err
    );

    modport slave (
        input  start, stop, j, k, mode, bit_in, bit_valid,
        output bit_ready, samp_out, samp_valid, samp_idx, busy, done, err
    );
endinterface

// File: rtl/rice_block_decoder.sv
// Rice block decoder: serial bits in, j samples per block out (unary quotient + k-bit
// remainder, or raw DATA_W-bit bypass), with quotient-overflow error detection.
module rice_block_decoder #(
    parameter int unsigned J_W    = 6,
    parameter int unsigned K_W    = 5,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned QMAX   = 64
) (
    input logic                 clk,
    input logic                 reset,
    rice_block_decoder_if.slave bus
);
    localparam int unsigned Q_W  = $clog2(QMAX + 1);
    localparam int unsigned RB_W = $clog2(DATA_W + 1);
    localparam int unsigned BC_W = (K_W > RB_W) ? K_W : RB_W;

    typedef enum logic [2:0] {StIdle, StQuot, StRem, StRaw, StEmit, StDone} state_e;

    state_e            state_q, state_d;
    logic [J_W-1:0]    j_q, cnt_q;
    logic [K_W-1:0]    k_q;
    logic              mode_q;
    logic [Q_W-1:0]    q_q;
    logic [DATA_W-1:0] sr_q, hold_q;
    logic [BC_W-1:0]   bcnt_q;
    logic              err_q;

    logic              accept, last_rem, last_raw, q_ovf, last_samp;
    logic [DATA_W-1:0] emit_val;

    assign bus.bit_ready  = (state_q == StQuot) || (state_q == StRem) || (state_q == StRaw);
    assign accept         = bus.bit_valid && bus.bit_ready;
    assign last_rem       = (bcnt_q + BC_W'(1)) == BC_W'(k_q);
    assign last_raw       = (bcnt_q + BC_W'(1)) == BC_W'(DATA_W);
    assign q_ovf          = q_q == Q_W'(QMAX - 1);
    assign last_samp      = (cnt_q + J_W'(1)) == j_q;
    // Shifting past DATA_W drops the quotient entirely, leaving only r's low bits.
    assign emit_val       = mode_q ? sr_q : ((DATA_W'(q_q) << k_q) | sr_q);

    assign bus.samp_valid = state_q == StEmit;
    assign bus.samp_out   = (state_q == StEmit) ? emit_val : hold_q;
    assign bus.samp_idx   = cnt_q;
    assign bus.busy       = state_q != StIdle;
    assign bus.done       = state_q == StDone;
    assign bus.err        = err_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.j == '0)    state_d = StDone;
                    else if (bus.mode)  state_d = StRaw;
                    else                state_d = StQuot;
                end
            end
            StQuot: begin
                if (accept) begin
                    if (bus.bit_in) state_d = (k_q != '0) ? StRem : StEmit;
                    else if (q_ovf) state_d = StDone;
                end
            end
            StRem:  if (accept && last_rem) state_d = StEmit;
            StRaw:  if (accept && last_raw) state_d = StEmit;
            StEmit: state_d = last_samp ? StDone : (mode_q ? StRaw : StQuot);
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.stop) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            j_q    <= '0;
            k_q    <= '0;
            mode_q <= 1'b0;
            q_q    <= '0;
            sr_q   <= '0;
            bcnt_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            hold_q <= '0;
        end else if (bus.stop) begin
            q_q    <= '0;
            sr_q   <= '0;
            bcnt_q <= '0;
            cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        j_q    <= bus.j;
                        k_q    <= bus.k;
                        mode_q <= bus.mode;
                        err_q  <= 1'b0;
                        q_q    <= '0;
                        sr_q   <= '0;
                        bcnt_q <= '0;
                        cnt_q  <= '0;
                    end
                end
                StQuot: begin
                    if (accept) begin
                        if (bus.bit_in) begin
                            sr_q   <= '0;
                            bcnt_q <= '0;
                        end else begin
                            q_q <= q_q + Q_W'(1);
                            if (q_ovf) err_q <= 1'b1;
                        end
                    end
                end
                StRem, StRaw: begin
                    if (accept) begin
                        sr_q   <= DATA_W'({sr_q, bus.bit_in});
                        bcnt_q <= bcnt_q + BC_W'(1);
                    end
                end
                StEmit: begin
                    hold_q <= emit_val;
                    cnt_q  <= cnt_q + J_W'(1);
                    q_q    <= '0;
                    sr_q   <= '0;
                    bcnt_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
